// File: rtl/ctrl_decode_pipe.sv
// rtl/ctrl_decode_pipe.sv - registered RV32 decode stage with 2-entry skid buffer and sticky EBREAK halt
// Decoded entries live in an output register plus one skid slot; o_ready/o_valid are flops fed from next state.
module ctrl_decode_pipe #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_inst,
  input  logic [XLEN-1:0]  i_pc,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_inst,
  output logic [XLEN-1:0]  o_pc,
  output logic [5:0]       o_inst_format,
  output logic             o_RegWrite,
  output logic             o_ALUSrc1,
  output logic             o_ALUSrc2,
  output logic             o_lui,
  output logic             o_dmem_ren,
  output logic             o_dmem_wen,
  output logic             o_MemtoReg,
  output logic             o_Jump,
  output logic             o_Branch,
  output logic [1:0]       o_ALUop,
  output logic             o_mul,
  output logic             o_illegal,
  output logic             o_retire_halt,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_dec_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [5:0] FMT_R = 6'b000001;
  localparam logic [5:0] FMT_I = 6'b000010;
  localparam logic [5:0] FMT_S = 6'b000100;
  localparam logic [5:0] FMT_B = 6'b001000;
  localparam logic [5:0] FMT_U = 6'b010000;
  localparam logic [5:0] FMT_J = 6'b100000;

  localparam logic [31:0] EBREAK = 32'h00100073;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [5:0]      fmt;
    logic            reg_write;
    logic            alu_src1;
    logic            alu_src2;
    logic            lui;
    logic            dmem_ren;
    logic            dmem_wen;
    logic            mem_to_reg;
    logic            jump;
    logic            branch;
    logic [1:0]      alu_op;
    logic            mul;
    logic            illegal;
    logic            halt;
  } entry_t;

  typedef enum logic [2:0] {
    S_EMPTY,
    S_ONE,
    S_TWO,
    S_HALT_PEND,
    S_HALTED
  } state_t;

  state_t     state_q, state_d;
  logic       valid_q, valid_d;
  logic       ready_q, ready_d;
  logic       halted_q, halted_d;
  entry_t     dec_in;
  entry_t     out_q, skid_q;
  logic       skid_v_q;
  logic [CNT_W-1:0] cnt_q;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic       acc, drn, flush_act;

  assign opcode    = i_inst[6:0];
  assign funct7    = i_inst[31:25];
  assign acc       = i_valid && ready_q;
  assign drn       = valid_q && i_ready;
  assign flush_act = i_flush && (state_q != S_HALTED);

  // Illegal entries default to format I / ALUop 10 with every side-effect control low.
  always_comb begin
    dec_in        = '0;
    dec_in.inst   = i_inst;
    dec_in.pc     = i_pc;
    dec_in.fmt    = FMT_I;
    dec_in.alu_op = 2'b10;
    dec_in.halt   = (i_inst == EBREAK);
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'h00 || funct7 == 7'h20 || (ENABLE_M && funct7 == 7'h01)) begin
          dec_in.fmt       = FMT_R;
          dec_in.reg_write = 1'b1;
          dec_in.alu_op    = 2'b00;
          dec_in.mul       = ENABLE_M && (funct7 == 7'h01);
        end else begin
          dec_in.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_in.reg_write = 1'b1;
        dec_in.alu_src2  = 1'b1;
        dec_in.alu_op    = 2'b01;
      end
      OPC_LOAD: begin
        dec_in.reg_write  = 1'b1;
        dec_in.alu_src2   = 1'b1;
        dec_in.dmem_ren   = 1'b1;
        dec_in.mem_to_reg = 1'b1;
      end
      OPC_STORE: begin
        dec_in.fmt      = FMT_S;
        dec_in.alu_src2 = 1'b1;
        dec_in.dmem_wen = 1'b1;
      end
      OPC_BRANCH: begin
        dec_in.fmt    = FMT_B;
        dec_in.alu_op = 2'b11;
        dec_in.branch = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_in.fmt       = FMT_U;
        dec_in.reg_write = 1'b1;
        dec_in.alu_src1  = 1'b1;
        dec_in.alu_src2  = 1'b1;
        dec_in.lui       = (opcode == OPC_LUI);
      end
      OPC_JAL: begin
        dec_in.fmt       = FMT_J;
        dec_in.reg_write = 1'b1;
        dec_in.alu_src1  = 1'b1;
        dec_in.alu_src2  = 1'b1;
        dec_in.jump      = 1'b1;
      end
      OPC_JALR: begin
        dec_in.reg_write = 1'b1;
        dec_in.alu_src2  = 1'b1;
        dec_in.jump      = 1'b1;
      end
      OPC_SYSTEM: begin
      end
      default: dec_in.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_EMPTY;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      halted_q <= halted_d;
    end
  end

  // An accepted EBREAK is always the youngest entry, so the halt completes when it drains from out_q.
  always_comb begin
    state_d = state_q;
    if (flush_act) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY:     if (acc) state_d = dec_in.halt ? S_HALT_PEND : S_ONE;
        S_ONE: begin
          if (acc)      state_d = dec_in.halt ? S_HALT_PEND : (drn ? S_ONE : S_TWO);
          else if (drn) state_d = S_EMPTY;
        end
        S_TWO:       if (drn) state_d = S_ONE;
        S_HALT_PEND: if (drn && out_q.halt) state_d = S_HALTED;
        S_HALTED:    state_d = S_HALTED;
        default:     state_d = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    valid_d  = 1'b0;
    ready_d  = 1'b0;
    halted_d = 1'b0;
    case (state_d)
      S_EMPTY:     ready_d  = 1'b1;
      S_ONE: begin
        valid_d = 1'b1;
        ready_d = 1'b1;
      end
      S_TWO:       valid_d  = 1'b1;
      S_HALT_PEND: valid_d  = 1'b1;
      S_HALTED:    halted_d = 1'b1;
      default:     ready_d  = 1'b1;
    endcase
  end

  // Accept only happens with the skid slot empty, since o_ready is low whenever it is occupied.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q    <= '0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (drn) cnt_q <= cnt_q + CNT_W'(1);
      if (flush_act) begin
        skid_q   <= '0;
        skid_v_q <= 1'b0;
      end else if (acc) begin
        if (!valid_q || drn) begin
          out_q <= dec_in;
        end else begin
          skid_q   <= dec_in;
          skid_v_q <= 1'b1;
        end
      end else if (drn && skid_v_q) begin
        out_q    <= skid_q;
        skid_v_q <= 1'b0;
      end
    end
  end

  assign o_ready       = ready_q;
  assign o_valid       = valid_q;
  assign o_halted      = halted_q;
  assign o_dec_count   = cnt_q;
  assign o_inst        = out_q.inst;
  assign o_pc          = out_q.pc;
  assign o_inst_format = out_q.fmt;
  assign o_RegWrite    = out_q.reg_write;
  assign o_ALUSrc1     = out_q.alu_src1;
  assign o_ALUSrc2     = out_q.alu_src2;
  assign o_lui         = out_q.lui;
  assign o_dmem_ren    = out_q.dmem_ren;
  assign o_dmem_wen    = out_q.dmem_wen;
  assign o_MemtoReg    = out_q.mem_to_reg;
  assign o_Jump        = out_q.jump;
  assign o_Branch      = out_q.branch;
  assign o_ALUop       = out_q.alu_op;
  assign o_mul         = out_q.mul;
  assign o_illegal     = out_q.illegal;
  assign o_retire_halt = out_q.halt;

endmodule
